// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared state encoding and match-mode constants for the serial pattern detector
package seq_det_pkg;
  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_HUNT  = 2'd1,
    S_MATCH = 2'd2
  } state_t;
  localparam logic MODE_OVL  = 1'b0;
  localparam logic MODE_NOVL = 1'b1;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: clearable up-counter that sticks at all-ones
module sat_counter #(
  parameter int CW = 8
) (
  input  logic          ClkM,
  input  logic          RstM_n,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          sat
);
  assign sat = &cnt;
  always_ff @(posedge ClkM or negedge RstM_n)
    if (!RstM_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && !sat) cnt <= cnt + CW'(1);
endmodule

// File: rtl/moore_seq_detector.sv
// moore_seq_detector: Moore detector for a loadable N-bit serial pattern with
// overlapping/non-overlapping match modes and a saturating match counter
module moore_seq_detector
  import seq_det_pkg::*;
#(
  parameter int           N           = 4,
  parameter logic [N-1:0] DEFAULT_PAT = N'(4'b1011),
  parameter int           CW          = 8
) (
  input  logic          ClkM,
  input  logic          RstM_n,
  input  logic          En,
  input  logic          A,
  input  logic          Load,
  input  logic [N-1:0]  PatIn,
  input  logic          Mode,
  output logic          Z,
  output logic [CW-1:0] MatchCnt,
  output logic          CntSat
);
  localparam int FW = $clog2(N + 1);
  localparam logic [FW-1:0] FULL = FW'(N);
  state_t state, stateNx;
  logic [N-1:0] pat, patNx, hist, histNx, histShift;
  logic [FW-1:0] fill, fillNx, fillInc;
  logic hit;
  assign histShift = {hist[N-2:0], A};
  assign fillInc = (fill == FULL) ? fill : fill + FW'(1);
  assign hit = (fillInc == FULL) && (histShift == pat);
  assign Z = (state == S_MATCH);
  always_comb begin
    patNx = pat;
    histNx = hist;
    fillNx = fill;
    stateNx = state;
    if (Load) begin
      patNx = PatIn;
      histNx = '0;
      fillNx = '0;
      stateNx = S_FILL;
    end else if (En) begin
      histNx = (hit && Mode == MODE_NOVL) ? '0 : histShift;
      fillNx = hit ? ((Mode == MODE_NOVL) ? '0 : FULL) : fillInc;
      stateNx = hit ? S_MATCH : (fillInc == FULL) ? S_HUNT : S_FILL;
    end
  end
  always_ff @(posedge ClkM or negedge RstM_n)
    if (!RstM_n) begin
      pat <= DEFAULT_PAT;
      hist <= '0;
      fill <= '0;
      state <= S_FILL;
    end else begin
      pat <= patNx;
      hist <= histNx;
      fill <= fillNx;
      state <= stateNx;
    end
  sat_counter #(.CW(CW)) uCnt (
    .ClkM   (ClkM),
    .RstM_n (RstM_n),
    .inc    (En && !Load && hit),
    .clr    (Load),
    .cnt    (MatchCnt),
    .sat    (CntSat)
  );
endmodule

// File: doc/moore_seq_detector.md
Name: moore_seq_detector

Overview:
- Parametrised successor to the team's fixed 4-state Moore detector.
- Detects a runtime-loadable N-bit serial pattern on a 1-bit input stream.
- Supports overlapping and non-overlapping match modes and counts matches.
- Moore output Z is a function of registered state only; sits between serial front-end logic and status/debug registers.

Parameters:
- N, 4, pattern length in bits (2..32).
- DEFAULT_PAT, 4'b1011, pattern value after reset (N bits).
- CW, 8, match counter width.

Ports:
- ClkM  input  1  clock; all state changes on posedge.
- RstM_n  input  1  asynchronous active-low reset.
- En  input  1  A is a valid stream bit this cycle.
- A  input  1  serial data bit.
- Load  input  1  latch PatIn as the new pattern and clear detection state.
- PatIn  input  N  new pattern; PatIn[N-1] is the first bit received.
- Mode  input  1  0 = overlapping, 1 = non-overlapping; sampled on each En cycle.
- Z  output  1  Moore match output; 1 iff state is S_MATCH.
- MatchCnt  output  CW  number of matches since reset/Load; saturating.
- CntSat  output  1  MatchCnt has reached all-ones.

Behaviour:
- Reset (async, RstM_n=0):
  - Pat=DEFAULT_PAT, Hist=0, Fill=0, state=S_FILL.
  - Z=0, MatchCnt=0, CntSat=0.
- Registers:
  - Pat[N-1:0].
  - Hist[N-1:0], shift: Hist <= {Hist[N-2:0], A}.
  - Fill, 0..N, saturates at N.
  - state.
  - MatchCnt.
- States:
  - S_FILL: Fill<N.
  - S_HUNT: Fill==N, last window did not match.
  - S_MATCH: last window matched.
- On a cycle with En=1, Load=0:
  - Compute Hist' and Fill'=min(Fill+1, N); hit = (Fill'==N) && (Hist'==Pat).
  - hit: state->S_MATCH, MatchCnt+1 (unless saturated). Mode=1: Fill<=0, Hist<=0. Mode=0: Fill<=N, Hist<=Hist'.
  - no hit: Hist<=Hist', Fill<=Fill'; state = (Fill'==N) ? S_HUNT : S_FILL.
- En=0, Load=0: all state held; Z holds its value.
- Latency: Z rises the cycle after the En cycle carrying the final pattern bit. Z stays high until the next En or Load cycle.
- Back-to-back matches in overlap mode keep Z=1 continuously across consecutive En cycles. MatchCnt still increments per match.
- Load=1:
  - Pat<=PatIn, Hist<=0, Fill<=0, state<=S_FILL, Z<=0, MatchCnt<=0, CntSat<=0.
  - Load has priority over En; A is discarded that cycle.
- Saturation: when MatchCnt==2^CW-1, further hits leave it unchanged, CntSat=1, Z still asserts.
- Mode change mid-stream: takes effect from the next En cycle. No flush, no effect on Hist/Fill until a hit.
- Reset mid-stream: immediate async clear. The first bit after deassertion is treated as bit 1 of a new window.
- Outputs are registered; no combinational path from any input to Z, MatchCnt or CntSat.

Decomposition:
- Shared package (seq_det_pkg):
  - 2-bit state typedef/constants S_FILL=0, S_HUNT=1, S_MATCH=2.
  - Mode constants MODE_OVL=0, MODE_NOVL=1.
- Sub-module sat_counter (CW param; inc, clr, cnt, sat) holds the saturating match counter.
- FSM, history register and comparator stay in the top module.

Test Plan:
- Reset default, N=4: pulse RstM_n low mid-stream -> Z=0, MatchCnt=0 immediately. Then stream 1,0,1,1 with En=1 -> Z=1 the cycle after the 4th bit, MatchCnt=1.
- Overlap: Pat=1011, Mode=0, stream 1011011 -> Z high after bits 4 and 7, MatchCnt=2. Pat=1111, stream eight 1s -> MatchCnt=5, Z continuously high from bit 4.
- Non-overlap: Pat=1111, Mode=1, eight 1s -> matches after bits 4 and 8, MatchCnt=2. Pat=1011, stream 1011011 -> MatchCnt=1.
- En gaps: insert En=0 idle cycles between every bit of 1011 -> same MatchCnt=1. Z is held across idle cycles after the match, and is not set earlier.
- Load priority: Load=1 with En=1, A=1, PatIn=0110 on the same cycle -> Pat=0110, Fill=0, Z=0, MatchCnt=0. Next stream 0110 -> MatchCnt=1.
- Saturation, CW=2: Pat=1111, Mode=0, ten 1s -> MatchCnt=3, CntSat=1 after the 3rd match; Z remains 1 on later matches.
